// File: rtl/pair_triple_event_monitor.sv
// rtl/pair_triple_event_monitor.sv - run/event statistics for the pair/triple detector output; PAIR_TRIPLE_MONITOR_LONGEST_EN enables the longest-run tracker
module pair_triple_event_monitor #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det,
    input  logic             clear,
    output logic             in_run,
    output logic [nbits-1:0] event_count,
    output logic [nbits-1:0] run_len,
    output logic [nbits-1:0] longest
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [nbits-1:0] MAX_VAL  = '1;
    localparam logic [nbits-1:0] ONE_VAL  = 1;
    localparam logic [nbits-1:0] ZERO_VAL = '0;

    state_t           state_q, state_d;
    logic [nbits-1:0] count_q, count_d;
    logic [nbits-1:0] run_q, run_d;
    logic             wipe;

    // reset and soft clear share one wipe path; reset is also applied in the register
    assign wipe = reset | clear;

    // state and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= ZERO_VAL;
            run_q   <= ZERO_VAL;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

    // next state plus saturating event and run-length updates
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        run_d   = run_q;
        if (wipe) begin
            state_d = IDLE;
            count_d = ZERO_VAL;
            run_d   = ZERO_VAL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (det) begin
                        state_d = RUN;
                        count_d = (count_q == MAX_VAL) ? count_q : count_q + ONE_VAL;
                        run_d   = ONE_VAL;
                    end
                end
                RUN: begin
                    if (det) begin
                        run_d = (run_q == MAX_VAL) ? run_q : run_q + ONE_VAL;
                    end else begin
                        state_d = IDLE;
                        run_d   = ZERO_VAL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PAIR_TRIPLE_MONITOR_LONGEST_EN
    logic [nbits-1:0] longest_q, longest_d;

    // longest tracks the next run length so a new maximum shows in the same cycle
    always_comb begin
        longest_d = longest_q;
        if (wipe) begin
            longest_d = ZERO_VAL;
        end else if (run_d > longest_q) begin
            longest_d = run_d;
        end
    end

    // longest-run register
    always_ff @(posedge clk) begin
        if (reset) begin
            longest_q <= ZERO_VAL;
        end else begin
            longest_q <= longest_d;
        end
    end
`endif

    // outputs come straight from registers
    always_comb begin
        in_run      = (state_q == RUN);
        event_count = count_q;
        run_len     = run_q;
`ifdef PAIR_TRIPLE_MONITOR_LONGEST_EN
        longest     = longest_q;
`else
        longest     = ZERO_VAL;
`endif
    end

endmodule

// File: tb/tb_pair_triple_event_monitor.sv
// tb/tb_pair_triple_event_monitor.sv - directed vector bench for pair_triple_event_monitor
module tb_pair_triple_event_monitor;

`ifdef PAIR_TRIPLE_MONITOR_LONGEST_EN
    localparam bit LEN = 1'b1;
`else
    localparam bit LEN = 1'b0;
`endif

    logic       clk;
    logic       reset, det, clear;
    logic       in_run;
    logic [7:0] event_count, run_len, longest;

    logic       s_reset, s_det, s_clear;
    logic       s_in_run;
    logic [1:0] s_event_count, s_run_len, s_longest;

    int total;
    int bad;

    typedef struct {
        logic r;
        logic c;
        logic d;
        int   ir;
        int   ec;
        int   rl;
        int   lg;
    } vec_t;

    vec_t vecs[$];

    pair_triple_event_monitor #(.nbits(8)) dut (
        .clk(clk), .reset(reset), .det(det), .clear(clear),
        .in_run(in_run), .event_count(event_count), .run_len(run_len), .longest(longest)
    );

    pair_triple_event_monitor #(.nbits(2)) dut_sat (
        .clk(clk), .reset(s_reset), .det(s_det), .clear(s_clear),
        .in_run(s_in_run), .event_count(s_event_count), .run_len(s_run_len), .longest(s_longest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic d,
                       input int ir, input int ec, input int rl, input int lg);
        vec_t v;
        v.r = r; v.c = c; v.d = d; v.ir = ir; v.ec = ec; v.rl = rl; v.lg = lg;
        vecs.push_back(v);
    endtask

    task automatic sat_step(input logic d, input string tag, input int ec, input int rl, input int lg);
        s_det = d;
        @(posedge clk); #1;
        chk({tag, ".in_run"}, int'(s_in_run), int'(d));
        chk({tag, ".event_count"}, int'(s_event_count), ec);
        chk({tag, ".run_len"}, int'(s_run_len), rl);
        chk({tag, ".longest"}, int'(s_longest), LEN ? lg : 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; clear = 1'b0; det = 1'b0;
        s_reset = 1'b1; s_clear = 1'b0; s_det = 1'b0;

        // reset held with det high, then release
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        // runs: det 1,1,1,0,1,0
        add(0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 1, 1, 1, 2, 2);
        add(0, 0, 1, 1, 1, 3, 3);
        add(0, 0, 0, 0, 1, 0, 3);
        add(0, 0, 1, 1, 2, 1, 3);
        add(0, 0, 0, 0, 2, 0, 3);
        // run of length 4 then clear with det high
        add(0, 0, 1, 1, 3, 1, 3);
        add(0, 0, 1, 1, 3, 2, 3);
        add(0, 0, 1, 1, 3, 3, 3);
        add(0, 0, 1, 1, 3, 4, 4);
        add(0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 0, 1, 0, 1);
        // reset and clear together, then single-cycle pulses
        add(1, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 1, 2, 1, 1);
        add(0, 0, 0, 0, 2, 0, 1);
        // clear held as a level with det high
        add(0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            reset = vecs[i].r;
            clear = vecs[i].c;
            det   = vecs[i].d;
            @(posedge clk); #1;
            chk($sformatf("v%0d.in_run", i), int'(in_run), vecs[i].ir);
            chk($sformatf("v%0d.event_count", i), int'(event_count), vecs[i].ec);
            chk($sformatf("v%0d.run_len", i), int'(run_len), vecs[i].rl);
            chk($sformatf("v%0d.longest", i), int'(longest), LEN ? vecs[i].lg : 0);
        end

        // saturation with nbits=2
        s_reset = 1'b1; s_det = 1'b1;
        @(posedge clk); #1;
        chk("sat.reset.run_len", int'(s_run_len), 0);
        s_reset = 1'b0;
        sat_step(1'b1, "sat.r1", 1, 1, 1);
        sat_step(1'b1, "sat.r2", 1, 2, 2);
        sat_step(1'b1, "sat.r3", 1, 3, 3);
        sat_step(1'b1, "sat.r4", 1, 3, 3);
        sat_step(1'b1, "sat.r5", 1, 3, 3);
        sat_step(1'b1, "sat.r6", 1, 3, 3);
        sat_step(1'b0, "sat.end", 1, 0, 3);
        for (int p = 0; p < 5; p++) begin
            sat_step(1'b1, $sformatf("sat.p%0d.hi", p), (p + 2 > 3) ? 3 : p + 2, 1, 3);
            sat_step(1'b0, $sformatf("sat.p%0d.lo", p), (p + 2 > 3) ? 3 : p + 2, 0, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
